// File: rtl/test_pattern_gen.sv
// Video test pattern generator: colour bars, split bars, animated checker and grid.
// Pixel output is registered one cycle behind the beam position inputs.
module test_pattern_gen #(
    parameter int unsigned H_DISPLAY  = 256,
    parameter int unsigned V_DISPLAY  = 240,
    parameter int unsigned NUM_BARS   = 7,
    parameter int unsigned SPLIT_ROW  = 160,
    parameter int unsigned CHECK_LOG2 = 4,
    parameter int unsigned GRID_LOG2  = 5,
    parameter int unsigned ANIM_LOG2  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic [1:0] mode_in,
    input  logic       mode_load,
    output logic [2:0] rgb,
    output logic [1:0] mode,
    output logic       frame_tick
);

    localparam int unsigned POS_W     = 9;
    localparam int unsigned BAR_W     = 3;
    localparam int unsigned BAR_WIDTH = H_DISPLAY / NUM_BARS;

    localparam logic [POS_W-1:0] CNT_LAST  = POS_W'(BAR_WIDTH - 1);
    localparam logic [BAR_W-1:0] BAR_LAST  = BAR_W'(NUM_BARS - 1);
    localparam logic [POS_W-1:0] H_LAST    = POS_W'(H_DISPLAY - 1);
    localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_DISPLAY - 1);
    localparam logic [POS_W-1:0] SPLIT_POS = POS_W'(SPLIT_ROW);

    logic [POS_W-1:0]     cnt_q, cnt_d;
    logic [BAR_W-1:0]     bar_q, bar_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           pend_q, pend_d;
    logic [ANIM_LOG2-1:0] fcnt_q, fcnt_d;
    logic                 phase_q, phase_d;
    logic [2:0]           rgb_q, rgb_d;
    logic                 tick_q, tick_d;

    logic                 frame_start_c;
    logic [POS_W-1:0]     cnt_cur_c;
    logic [BAR_W-1:0]     bar_cur_c;
    logic [2:0]           pix_c;
    logic                 chk_c;

    // Bar index i maps to {r,g,b} = {~i[1], ~i[2], ~i[0]}.
    function automatic logic [2:0] bar_colour(input logic [BAR_W-1:0] i);
        return {~i[1], ~i[2], ~i[0]};
    endfunction

    // Next-state and pixel logic.
    always_comb begin
        cnt_d   = cnt_q;
        bar_d   = bar_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        pix_c   = 3'b000;
        chk_c   = 1'b0;

        frame_start_c = (hpos == '0) && (vpos == '0);

        // Counters restart combinationally on hpos==0 so pixel 0 is always bar 0.
        cnt_cur_c = (hpos == '0) ? '0 : cnt_q;
        bar_cur_c = (hpos == '0) ? '0 : bar_q;

        if (cnt_cur_c == CNT_LAST) begin
            cnt_d = '0;
            bar_d = (bar_cur_c == BAR_LAST) ? BAR_LAST : bar_cur_c + BAR_W'(1);
        end else begin
            cnt_d = cnt_cur_c + POS_W'(1);
            bar_d = bar_cur_c;
        end

        if (mode_load) begin
            pend_d = mode_in;
        end

        // A strobe on the frame-start cycle bypasses the pending register.
        if (frame_start_c) begin
            mode_d = mode_load ? mode_in : pend_q;
            fcnt_d = fcnt_q + ANIM_LOG2'(1);
            if (&fcnt_q) begin
                phase_d = ~phase_q;
            end
        end

        case (mode_d)
            2'd0: pix_c = bar_colour(bar_cur_c);
            2'd1: begin
                if (vpos < SPLIT_POS) begin
                    pix_c = bar_colour(bar_cur_c);
                end else if (bar_cur_c[0]) begin
                    pix_c = 3'b000;
                end else begin
                    pix_c = bar_colour(BAR_W'(6) - bar_cur_c);
                end
            end
            2'd2: begin
                chk_c = hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2] ^ phase_q;
                pix_c = {3{chk_c}};
            end
            default: begin
                if ((hpos[GRID_LOG2-1:0] == '0) || (vpos[GRID_LOG2-1:0] == '0) ||
                    (hpos == H_LAST) || (vpos == V_LAST)) begin
                    pix_c = 3'b111;
                end
            end
        endcase

        rgb_d  = display_on ? pix_c : 3'b000;
        tick_d = frame_start_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            bar_q   <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            rgb_q   <= 3'b000;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    assign rgb        = rgb_q;
    assign mode       = mode_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed, table-driven bench for test_pattern_gen at default parameters.
module tb_test_pattern_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_on = 1'b0;
    logic [8:0] hpos = '0;
    logic [8:0] vpos = '0;
    logic [1:0] mode_in = '0;
    logic       mode_load = 1'b0;
    logic [2:0] rgb;
    logic [1:0] mode;
    logic       frame_tick;

    int n_cmp = 0;
    int n_err = 0;
    int fs_total = 0;

    typedef struct {
        logic [1:0] md;
        logic [8:0] v;
        logic [8:0] h;
        logic [2:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    test_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .mode_in    (mode_in),
        .mode_load  (mode_load),
        .rgb        (rgb),
        .mode       (mode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (hpos=%0d vpos=%0d)", name, act, exp, hpos, vpos);
        end
    endtask

    // One input cycle; outputs for it are readable on return.
    task automatic apply(input logic [8:0] h, input logic [8:0] v, input logic don,
                         input logic [1:0] mi, input logic ml, input logic rst);
        @(negedge clk);
        hpos = h; vpos = v; display_on = don; mode_in = mi; mode_load = ml; reset = rst;
        @(posedge clk);
        #1;
        if (rst) fs_total = 0;
        else if (h == 9'd0 && v == 9'd0) fs_total++;
    endtask

    function automatic logic [2:0] checker_exp(input logic [8:0] h, input logic [8:0] v);
        logic ph;
        ph = ((fs_total / 32) % 2) == 1;
        return {3{h[4] ^ v[4] ^ ph}};
    endfunction

    task automatic sweep(input logic [1:0] md, input logic [8:0] v);
        for (int h = 0; h < 256; h++) begin
            apply(9'(h), v, 1'b1, 2'd0, 1'b0, 1'b0);
            for (int k = 0; k < NV; k++)
                if (vecs[k].md == md && vecs[k].v == v && vecs[k].h == 9'(h))
                    check("bar", rgb, vecs[k].exp);
        end
    endtask

    task automatic chk_px(input string name, input logic [8:0] h, input logic [8:0] v,
                          input logic don, input logic [2:0] exp);
        apply(h, v, don, 2'd0, 1'b0, 1'b0);
        check(name, rgb, exp);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 9'd10, 9'd0,   3'b111};
        vecs[1]  = '{2'd0, 9'd10, 9'd36,  3'b110};
        vecs[2]  = '{2'd0, 9'd10, 9'd72,  3'b011};
        vecs[3]  = '{2'd0, 9'd10, 9'd108, 3'b010};
        vecs[4]  = '{2'd0, 9'd10, 9'd144, 3'b101};
        vecs[5]  = '{2'd0, 9'd10, 9'd180, 3'b100};
        vecs[6]  = '{2'd0, 9'd10, 9'd216, 3'b001};
        vecs[7]  = '{2'd0, 9'd10, 9'd252, 3'b001};
        vecs[8]  = '{2'd0, 9'd10, 9'd253, 3'b001};
        vecs[9]  = '{2'd0, 9'd10, 9'd254, 3'b001};
        vecs[10] = '{2'd0, 9'd10, 9'd255, 3'b001};
        vecs[11] = '{2'd1, 9'd200, 9'd0,   3'b001};
        vecs[12] = '{2'd1, 9'd200, 9'd36,  3'b000};
        vecs[13] = '{2'd1, 9'd200, 9'd72,  3'b101};
        vecs[14] = '{2'd1, 9'd200, 9'd108, 3'b000};
        vecs[15] = '{2'd1, 9'd200, 9'd144, 3'b011};
        vecs[16] = '{2'd1, 9'd200, 9'd180, 3'b000};
        vecs[17] = '{2'd1, 9'd200, 9'd216, 3'b111};
        vecs[18] = '{2'd1, 9'd10,  9'd0,   3'b111};
        vecs[19] = '{2'd1, 9'd10,  9'd36,  3'b110};
        vecs[20] = '{2'd1, 9'd10,  9'd252, 3'b001};

        // Reset state, including a strobe and frame start while held.
        apply(9'd0, 9'd0, 1'b1, 2'd3, 1'b1, 1'b1);
        check("rst_rgb", rgb, 3'b000);
        check("rst_mode", {1'b0, mode}, 3'd0);
        check("rst_tick", {2'b0, frame_tick}, 3'd0);
        apply(9'd16, 9'd16, 1'b1, 2'd0, 1'b0, 1'b1);
        check("rst_rgb2", rgb, 3'b000);

        // First frame start after reset.
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("fs_tick", {2'b0, frame_tick}, 3'd1);
        check("fs_mode", {1'b0, mode}, 3'd0);
        check("fs_rgb", rgb, 3'b111);
        apply(9'd5, 9'd5, 1'b1, 2'd0, 1'b0, 1'b0);
        check("tick_low", {2'b0, frame_tick}, 3'd0);

        sweep(2'd0, 9'd10);

        // Mid-frame strobe waits for the frame start.
        apply(9'd5, 9'd50, 1'b1, 2'd1, 1'b1, 1'b0);
        check("mode_hold", {1'b0, mode}, 3'd0);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("mode1", {1'b0, mode}, 3'd1);
        check("mode1_tick", {2'b0, frame_tick}, 3'd1);
        sweep(2'd1, 9'd10);
        sweep(2'd1, 9'd200);

        // Last strobe wins; strobe on frame start bypasses.
        apply(9'd3, 9'd20, 1'b1, 2'd3, 1'b1, 1'b0);
        apply(9'd4, 9'd20, 1'b1, 2'd1, 1'b1, 1'b0);
        check("two_strobe_hold", {1'b0, mode}, 3'd1);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("last_wins", {1'b0, mode}, 3'd1);
        apply(9'd0, 9'd0, 1'b1, 2'd3, 1'b1, 1'b0);
        check("bypass", {1'b0, mode}, 3'd3);

        chk_px("grid_32_5", 9'd32, 9'd5, 1'b1, 3'b111);
        chk_px("grid_33_5", 9'd33, 9'd5, 1'b1, 3'b000);
        chk_px("grid_255_7", 9'd255, 9'd7, 1'b1, 3'b111);
        chk_px("grid_vlast", 9'd100, 9'd239, 1'b1, 3'b111);
        chk_px("grid_off", 9'd100, 9'd100, 1'b1, 3'b000);
        chk_px("grid_blank", 9'd32, 9'd5, 1'b0, 3'b000);

        // Checker mode and phase animation.
        apply(9'd7, 9'd100, 1'b1, 2'd2, 1'b1, 1'b0);
        check("mode2_hold", {1'b0, mode}, 3'd3);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("mode2", {1'b0, mode}, 3'd2);
        chk_px("chk_16_0", 9'd16, 9'd0, 1'b1, 3'b111);
        chk_px("chk_16_16", 9'd16, 9'd16, 1'b1, checker_exp(9'd16, 9'd16));
        chk_px("chk_0_16", 9'd0, 9'd16, 1'b1, checker_exp(9'd0, 9'd16));
        while (fs_total < 31) apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk_px("chk_pre_flip", 9'd16, 9'd0, 1'b1, 3'b111);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk_px("chk_flip", 9'd16, 9'd0, 1'b1, 3'b000);
        chk_px("chk_flip_16_16", 9'd16, 9'd16, 1'b1, checker_exp(9'd16, 9'd16));
        chk_px("chk_flip_0_0x", 9'd32, 9'd32, 1'b1, checker_exp(9'd32, 9'd32));

        // Mid-frame reset with a pending mode queued.
        apply(9'd3, 9'd60, 1'b1, 2'd3, 1'b1, 1'b0);
        apply(9'd50, 9'd50, 1'b1, 2'd0, 1'b0, 1'b1);
        check("mid_rst_rgb", rgb, 3'b000);
        check("mid_rst_mode", {1'b0, mode}, 3'd0);
        check("mid_rst_tick", {2'b0, frame_tick}, 3'd0);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b1);
        check("rst_fs_tick", {2'b0, frame_tick}, 3'd0);
        apply(9'd50, 9'd50, 1'b1, 2'd0, 1'b0, 1'b0);
        check("resume_rgb", rgb, 3'b111);
        check("resume_mode", {1'b0, mode}, 3'd0);
        apply(9'd0, 9'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("pend_cleared", {1'b0, mode}, 3'd0);
        check("resume_tick", {2'b0, frame_tick}, 3'd1);
        chk_px("blank_fs", 9'd0, 9'd0, 1'b0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
